pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 21 ++
 rtl/sat_counter.sv | 27 ++
 rtl/pipe_stage_reg.sv | 180 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: FSM state encodings for the holding stage,
// the zero-payload constant used by reset/flush, and a small state helper.
package pipe_stage_reg_pkg;

  // Widest payload any pipeline stage may carry.
  localparam int unsigned PAYLOAD_W_MAX = 256;

  // Holding-stage FSM encodings; the encoding doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // All-zero payload; stages slice the low bits they need.
  localparam logic [PAYLOAD_W_MAX-1:0] ZERO_PAYLOAD = {PAYLOAD_W_MAX{1'b0}};

  // True when the given state holds at least one entry.
  function automatic logic state_holds_entry(input logic [1:0] st);
    return (st != ST_EMPTY);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear. Clear wins over increment;
// once the count reaches all-ones it stays there until cleared.
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_r;

  // Count up on inc, stop at all-ones, return to zero on clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (inc && (count_r != {CW{1'b1}})) begin
      count_r <= count_r + CW'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline holding stage with valid/ready handshakes on both sides.
//
// Build option PIPE_STAGE_SKID_EN:
//   defined   - two-entry stage (main + skid register) with a registered
//               in_ready, so out_ready has no combinational path upstream.
//   undefined - single main register; in_ready = !out_valid | out_ready.
//
// resetn is synchronous and active-high (1 = reset). Reset beats flush,
// flush beats all handshake activity. bubble_cnt counts cycles spent with
// out_valid low since the last reset and saturates at all-ones.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned W              = 32,
  parameter int unsigned CW             = 16,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [1:0]    occupancy,
  output logic [CW-1:0] bubble_cnt
);

  localparam logic [W-1:0] ZERO_W = ZERO_PAYLOAD[W-1:0];

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [W-1:0] main_r;
  logic [W-1:0] main_nxt_s;
  logic         out_valid_r;
  logic         in_fire_s;
  logic         out_fire_s;

`ifdef PIPE_STAGE_SKID_EN
  logic [W-1:0] skid_r;
  logic [W-1:0] skid_nxt_s;
  logic         in_ready_r;

  assign in_ready = in_ready_r;
`else
  assign in_ready = (~out_valid_r) | out_ready;
`endif

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid_r & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  // Two-entry next state: main feeds the output, skid absorbs one extra entry.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_nxt_s = ZERO_W;
        skid_nxt_s = ZERO_W;
      end else begin
        main_nxt_s = main_r;
        skid_nxt_s = skid_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else if (in_fire_s) begin
            state_nxt_s = ST_TWO;
            skid_nxt_s  = in_data;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end
`else
  // Single-entry next state: a new entry can only land when main is free or draining.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_nxt_s = ZERO_W;
      end else begin
        main_nxt_s = main_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end
`endif

  // Stage registers; reset clears everything and reopens the input.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_r     <= ST_EMPTY;
      main_r      <= ZERO_W;
      out_valid_r <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_r      <= ZERO_W;
      in_ready_r  <= 1'b1;
`endif
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      out_valid_r <= state_holds_entry(state_nxt_s);
`ifdef PIPE_STAGE_SKID_EN
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
`endif
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = state_r;

  sat_counter #(
    .CW (CW)
  ) u_bubble_cnt (
    .clk   (clk),
    .clear (resetn),
    .inc   (~out_valid_r),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. A queue-based reference model
// (capacity 2 with PIPE_STAGE_SKID_EN, otherwise 1) tracks the expected
// contents; directed sequences and a streaming vector table add fixed
// expectations, followed by randomized traffic.
module tb_pipe_stage_reg;

  localparam int W  = 32;
  localparam int CW = 3;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]  mq[$];
  logic [CW-1:0] m_bub;
  bit            m_zero;
  logic [W-1:0]  delivered[$];

  typedef struct {
    bit           iv;
    bit           ordy;
    logic [W-1:0] din;
    bit           exp_ov;
    bit           exp_ir;
    logic [1:0]   exp_occ;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .W              (W),
    .CW             (CW),
    .CLEAR_ON_FLUSH (1'b1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  function automatic bit model_in_ready();
    if (CAP == 2) return (mq.size() < 2);
    else return (mq.size() == 0) || (out_ready == 1'b1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("model_in_ready", 64'(in_ready), 64'(model_in_ready()));
    chk("model_occupancy", 64'(occupancy), 64'(mq.size()));
    chk("model_bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    if (mq.size() != 0) chk("model_out_data", 64'(out_data), 64'(mq[0]));
    else if (m_zero) chk("model_out_data_zero", 64'(out_data), 64'd0);
  endtask

  // Advance the reference model across one rising edge (inputs still held).
  task automatic model_edge();
    bit inr;
    bit was_empty;
    inr       = model_in_ready();
    was_empty = (mq.size() == 0);
    if (resetn) begin
      mq.delete();
      m_bub  = '0;
      m_zero = 1'b1;
    end else begin
      if (was_empty && (m_bub != 3'd7)) m_bub = m_bub + 3'd1;
      if (flush) begin
        mq.delete();
        m_zero = 1'b1;
      end else begin
        if (!was_empty && out_ready) void'(mq.pop_front());
        if (in_valid && inr) begin
          mq.push_back(in_data);
          m_zero = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit iv, input logic [W-1:0] d, input bit ordy);
    @(negedge clk);
    resetn    = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic finish_cycle();
    if (out_valid === 1'b1 && out_ready === 1'b1) delivered.push_back(out_data);
    @(posedge clk);
    model_edge();
  endtask

  task automatic cyc(input bit r, input bit f, input bit iv, input logic [W-1:0] d, input bit ordy, input bit do_chk);
    drive(r, f, iv, d, ordy);
    if (do_chk) check_model();
    finish_cycle();
  endtask

  initial begin
    logic [W-1:0] a_v;
    logic [W-1:0] b_v;
    logic [W-1:0] c_v;
    bit           c_pending;
    bit           acc;

    resetn = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mq.delete(); m_bub = '0; m_zero = 1'b1;
    a_v = 32'hA; b_v = 32'hB; c_v = 32'hC;

    // Streaming table: latency 1, back-to-back, occupancy 1.
    vecs[0] = '{1'b1, 1'b1, 32'h1, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h2, 1'b1, 1'b1, 2'd1, 32'h1};
    vecs[2] = '{1'b1, 1'b1, 32'h3, 1'b1, 1'b1, 2'd1, 32'h2};
    vecs[3] = '{1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 2'd1, 32'h3};
    vecs[4] = '{1'b1, 1'b1, 32'h5, 1'b1, 1'b1, 2'd1, 32'h4};
    vecs[5] = '{1'b1, 1'b1, 32'h6, 1'b1, 1'b1, 2'd1, 32'h5};
    vecs[6] = '{1'b1, 1'b1, 32'h7, 1'b1, 1'b1, 2'd1, 32'h6};
    vecs[7] = '{1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 2'd1, 32'h7};
    vecs[8] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 2'd1, 32'h8};
    vecs[9] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 2'd0, 32'h0};

    // Reset held for two cycles with traffic offered.
    cyc(1'b1, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h78, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    check_model();
    finish_cycle();

    // Bubble counter saturation with the stage idle.
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("sat_bubble_cnt", 64'(bubble_cnt), (k < 7) ? 64'(k) : 64'd7);
      check_model();
      finish_cycle();
    end

    // Streaming vectors.
    delivered.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      chk("stream_out_valid", 64'(out_valid), 64'(vecs[i].exp_ov));
      chk("stream_in_ready", 64'(in_ready), 64'(vecs[i].exp_ir));
      chk("stream_occupancy", 64'(occupancy), 64'(vecs[i].exp_occ));
      if (vecs[i].exp_ov) chk("stream_out_data", 64'(out_data), 64'(vecs[i].exp_data));
      check_model();
      finish_cycle();
    end
    chk("stream_count", 64'(delivered.size()), 64'd8);

    // Backpressure: A, B accepted, C held off, then drained in order.
    delivered.delete();
    cyc(1'b0, 1'b0, 1'b1, a_v, 1'b0, 1'b1);
`ifdef PIPE_STAGE_SKID_EN
    cyc(1'b0, 1'b0, 1'b1, b_v, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, c_v, 1'b0);
    chk("bp_occupancy_two", 64'(occupancy), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_is_a", 64'(out_data), 64'(a_v));
    check_model();
    finish_cycle();
`else
    drive(1'b0, 1'b0, 1'b1, b_v, 1'b0);
    chk("ns_in_ready_low", 64'(in_ready), 64'd0);
    chk("ns_occupancy_one", 64'(occupancy), 64'd1);
    check_model();
    out_ready = 1'b1;
    #1;
    chk("ns_in_ready_rise", 64'(in_ready), 64'd1);
    check_model();
    finish_cycle();
`endif
    c_pending = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, c_pending, c_v, 1'b1);
      check_model();
      acc = c_pending && model_in_ready();
      finish_cycle();
      if (acc) c_pending = 1'b0;
    end
    chk("bp_delivered_count", 64'(delivered.size()), 64'd3);
    if (delivered.size() == 3) begin
      chk("bp_order_0", 64'(delivered[0]), 64'(a_v));
      chk("bp_order_1", 64'(delivered[1]), 64'(b_v));
      chk("bp_order_2", 64'(delivered[2]), 64'(c_v));
    end

    // Flush while full with a new entry offered.
    delivered.delete();
    cyc(1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h12, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'hD, 1'b0);
    chk("flush_pre_occupancy", 64'(occupancy), 64'(CAP));
    check_model();
    finish_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_data", 64'(out_data), 64'd0);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    check_model();
    finish_cycle();
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("flush_nothing_delivered", 64'(delivered.size()), 64'd0);

    // Reset in the middle of a transfer.
    cyc(1'b0, 1'b0, 1'b1, 32'h21, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h55, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_occupancy", 64'(occupancy), 64'd0);
    chk("midreset_out_data", 64'(out_data), 64'd0);
    check_model();
    finish_cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
